// File: rtl/pb_debouncer.sv
// Push-button debouncer with single-, multi- and continuous-clock enables.
// Ports: board_clk, Reset (async, active-high), PB raw in; DPB, SCEN, MCEN, CCEN out.
module pb_debouncer #(
  parameter int N_DC = 20
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);

  typedef enum logic [2:0] {
    INI,
    WQ,
    SCEN_ST,
    WH,
    MCEN_ST,
    CCEN_ST,
    CCR,
    WFCR
  } state_t;

  state_t state_q, state_d;

  logic [N_DC-1:0] cnt_q, cnt_d;
  logic            pb_m_q, pb_m_d;
  logic            pb_s_q, pb_s_d;
  logic            cnt_max;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INI;
      cnt_q   <= '0;
      pb_m_q  <= 1'b0;
      pb_s_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_m_q  <= pb_m_d;
      pb_s_q  <= pb_s_d;
    end
  end

  always_comb begin
    pb_m_d = PB;
    pb_s_d = pb_m_q;
  end

  assign cnt_max = &cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INI: begin
        if (pb_s_q) state_d = WQ;
      end
      WQ: begin
        if (!pb_s_q)      state_d = INI;
        else if (cnt_max) state_d = SCEN_ST;
      end
      SCEN_ST: begin
        state_d = WH;
      end
      WH: begin
        if (!pb_s_q)      state_d = CCR;
        else if (cnt_max) state_d = MCEN_ST;
      end
      MCEN_ST: begin
        state_d = CCEN_ST;
      end
      CCEN_ST: begin
        if (!pb_s_q)      state_d = CCR;
        else if (cnt_max) state_d = MCEN_ST;
      end
      CCR: begin
        if (pb_s_q)       state_d = WFCR;
        else if (cnt_max) state_d = INI;
      end
      WFCR: begin
        if (!pb_s_q) state_d = CCR;
      end
      default: state_d = INI;
    endcase
  end

  // Cleared on any transition. In the idle-like stay states (INI, WFCR)
  // the count is not used, so it parks at max instead of wrapping.
  always_comb begin
    cnt_d = cnt_q + N_DC'(1);
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_max)       cnt_d = cnt_q;
  end

  always_comb begin
    DPB  = 1'b0;
    SCEN = 1'b0;
    MCEN = 1'b0;
    CCEN = 1'b0;
    unique case (state_q)
      INI, WQ: begin
      end
      SCEN_ST: begin
        DPB  = 1'b1;
        SCEN = 1'b1;
        MCEN = 1'b1;
        CCEN = 1'b1;
      end
      WH: begin
        DPB = 1'b1;
      end
      MCEN_ST: begin
        DPB  = 1'b1;
        MCEN = 1'b1;
        CCEN = 1'b1;
      end
      CCEN_ST: begin
        DPB  = 1'b1;
        CCEN = 1'b1;
      end
      CCR, WFCR: begin
        DPB = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/pb_debouncer.md
PB_DEBOUNCER -- requirements
Module: pb_debouncer

Interface
REQ-001 SHALL have parameter N_DC, default 20, debounce/repeat counter width (2^20 cycles is about 10.5 ms at 100 MHz).
REQ-002 SHALL have port board_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PB  input  1  raw push-button level, asynchronous, bouncy.
REQ-005 SHALL have port DPB  output  1  debounced button level.
REQ-006 SHALL have port SCEN  output  1  single-clock enable, one pulse per press.
REQ-007 SHALL have port MCEN  output  1  multiple-clock enable, one pulse per press plus periodic pulses while held.
REQ-008 SHALL have port CCEN  output  1  continuous-clock enable, high every cycle once hold is recognised.

Function
REQ-009 SHALL pass PB through a 2-flop synchronizer (PB_s); the FSM sees only PB_s.
REQ-010 SHALL hold an N_DC-bit counter that is cleared on every state transition and increments by 1 each cycle the state is held; "max" means all ones.
REQ-011 SHALL implement states INI, WQ, SCEN_ST, WH, MCEN_ST, CCEN_ST, CCR, WFCR, decoded Moore-style from the state register.
REQ-012 INI: PB_s=1 -> WQ; otherwise stay.
REQ-013 WQ: PB_s=0 -> INI; PB_s=1 with counter==max -> SCEN_ST; otherwise stay.
REQ-014 SCEN_ST: lasts exactly one cycle, then -> WH.
REQ-015 WH: PB_s=0 -> CCR; PB_s=1 with counter==max -> MCEN_ST; otherwise stay.
REQ-016 MCEN_ST: lasts exactly one cycle, then -> CCEN_ST.
REQ-017 CCEN_ST: PB_s=0 -> CCR; PB_s=1 with counter==max -> MCEN_ST; otherwise stay.
REQ-018 CCR: PB_s=1 -> WFCR; PB_s=0 with counter==max -> INI; otherwise stay.
REQ-019 WFCR: PB_s=0 -> CCR (counter cleared, so release debounce restarts); otherwise stay.
REQ-020 DPB SHALL be 1 in SCEN_ST, WH, MCEN_ST, CCEN_ST, CCR and WFCR; 0 in INI and WQ.
REQ-021 SCEN SHALL be 1 only in SCEN_ST.
REQ-022 MCEN SHALL be 1 only in SCEN_ST and MCEN_ST.
REQ-023 CCEN SHALL be 1 only in SCEN_ST, MCEN_ST and CCEN_ST.
REQ-024 Press latency: with edge 0 defined as the first edge sampling PB=1, and PB stable high, SCEN SHALL be high for exactly the cycle after edge 2^N_DC+2.
REQ-025 Hold timing: the first repeat MCEN SHALL occur after edge 2^(N_DC+1)+3; later pulses SHALL repeat every 2^N_DC+1 cycles while PB is held.
REQ-026 Release latency: with edge r defined as the first edge sampling PB=0, and PB stable low, DPB SHALL fall after edge r+2^N_DC+2.
REQ-027 Bounce immunity: any PB_s=0 during WQ SHALL abort the press; any PB_s=1 during CCR SHALL restart release qualification.
REQ-028 Counter wrap: the counter SHALL never wrap silently; a max value always causes a transition or a stay per REQ-012..019, and it is cleared on that transition.

Reset
REQ-029 On Reset=1 (asynchronous, active-high), state=INI, counter=0, both synchronizer flops=0, and DPB=SCEN=MCEN=CCEN=0, immediately and independently of board_clk.
REQ-030 Reset asserted mid-operation (any state) SHALL abort with no further SCEN/MCEN pulse; after release, a held PB SHALL be treated as a new press per REQ-024.

Verification (bench uses N_DC=4)
REQ-031 Clean press: PB high edges 0..19, then low -> single SCEN/MCEN/CCEN pulse after edge 18, no repeat MCEN, DPB high from edge 18.
REQ-032 Bounce: PB high 10 cycles, low 1, high 10, low -> no SCEN, DPB stays 0; then PB high 30 cycles -> exactly one SCEN.
REQ-033 Long hold: PB high 100 cycles -> SCEN after edge 18; MCEN after edges 18, 35, 52, 69, 86; CCEN high continuously from edge 35 until PB_s=0.
REQ-034 Release with bounce: after hold, PB low 8 cycles, high 2, low steady -> DPB stays 1 through the bounce, falls 18 edges after the final falling sample; no SCEN or MCEN on release.
REQ-035 Reset mid-hold: assert Reset while in CCEN_ST with PB still high -> all outputs 0 at once; deassert -> next SCEN 18 edges after the first post-reset PB sample.
